systolic_loader: RTL
====================

# systolic_loader

Upstream fill stage of the systolic matrix multiply. Accepts a single valid/ready stream carrying matrix A and then matrix B. Each stream is row-major, M×M elements. Writes every element into the banked A and B buffer memories, laid out exactly as the read-side address generator consumes them:
- A bank i, slice s, column k at address s·M + k.
- B bank j, group g, row k at address g·M + k.

Pulses `load_done` when both matrices are resident so compute can begin.

## Interface
- `N1`, 4: A banks (array rows); power of 2, divides M.
- `N2`, 4: B banks (array columns); power of 2, divides M.
- `M`, 8: matrix dimension; power of 2, ≥ 2.
- `DW`, 8: element width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin a load; sampled only in IDLE.
- `in_valid` in 1: stream element valid.
- `in_data` in DW: stream element.
- `in_ready` out 1: stage accepts element.
- `wr_en_A` out N1: one-hot A bank write strobe.
- `wr_addr_A` out $clog2(M*M/N1): A bank address.
- `wr_data_A` out DW: A write data.
- `wr_en_B` out N2: one-hot B bank write strobe.
- `wr_addr_B` out $clog2(M*M/N2): B bank address.
- `wr_data_B` out DW: B write data.
- `busy` out 1: state ≠ IDLE.
- `load_done` out 1: one-cycle pulse, load complete.

## Operation
- FSM states and transitions:
  - IDLE → LOAD_A on `start`.
  - LOAD_A → LOAD_B on acceptance of the M·M-th A beat.
  - LOAD_B → DONE on acceptance of the M·M-th B beat.
  - DONE → IDLE unconditionally.
- Beat accepted when `in_valid && in_ready`. `in_ready` = 1 in LOAD_A and LOAD_B, 0 in IDLE and DONE.
- Position counters:
  - Row `r` and column `c` are each $clog2(M) bits.
  - `c` increments per accepted beat. When `c` wraps M−1→0, `r` increments.
  - Both clear on entry to LOAD_A and LOAD_B.
- A mapping, for beat (r,c):
  - bank = r mod N1.
  - addr = (r/N1)·M + c, i.e. concatenation {r >> log2 N1, c}.
- B mapping, for beat (r,c):
  - bank = c mod N2.
  - addr = (c/N2)·M + r, i.e. {c >> log2 N2, r}.
- Single-bank width rule: when N1 = 1 (or N2 = 1), the bank index is absent, the strobe is 1 bit, and it is always 1 on a write.
- `start` in any state other than IDLE is ignored.
- `in_valid` while not ready: the element is not consumed, and no write occurs.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and the counters are 0.
- Write latency is 1 cycle. A beat accepted at edge t drives `wr_en_*`, `wr_addr_*` and `wr_data_*` during cycle t+1. All outputs are registered.
- Strobes are high for exactly one cycle per accepted beat. A and B strobes are never high in the same cycle.
- Gapped `in_valid` yields gapped strobes. Between writes, address and data hold their last value and strobes are 0.
- LOAD_A→LOAD_B boundary: `in_ready` stays 1 across it, so back-to-back beats incur no bubble. The first B beat may be accepted the cycle after the last A beat.
- `load_done` is high during DONE. This coincides with the final B write (cycle t+1 after the last B beat). `in_ready` is 0 in that cycle.
- The earliest next `start` is sampled in the cycle after DONE. Minimum throughput is 2·M·M + 2 cycles per load.
- Reset asserted mid-load: all outputs drop to 0 asynchronously and the FSM returns to IDLE. Buffer contents are undefined until the next full load.

## Structure
- Shared package `systolic_pkg` holds:
  - The FSM state enum (IDLE, LOAD_A, LOAD_B, DONE).
  - A `clog2`-with-floor-1 width helper, matching the widths used by the read-side control.
  - Localparams for the A and B address widths.
- One sub-module, `rc_counter`: row/column counter with enable, synchronous clear, and a `last` flag (r = c = M−1). It is instantiated once and shared by both phases.
- The top level holds the FSM, the mapping logic and the output registers.

## Test plan
All scenarios use M = 8, N1 = N2 = 4, DW = 8, with `in_data` = beat index 0..127 unless noted.
- **Reset:** hold `rst` = 0 → all outputs 0 and `in_ready` = 0. Release, no `start` → outputs unchanged.
- **Full load, continuous valid, mapping checks:**
  - Beat 9 (A r1 c1) → `wr_en_A` = 0010, `wr_addr_A` = 1, `wr_data_A` = 9.
  - Beat 37 (A r4 c5) → `wr_en_A` = 0001, `wr_addr_A` = 13.
  - Beat 77 (B r1 c5) → `wr_en_B` = 0010, `wr_addr_B` = 9.
  - Exactly 64 A writes and 64 B writes.
  - `load_done` is a single pulse one cycle after beat 127 is accepted.
- **Random `in_valid` gaps:**
  - Identical address/data write sequence to the continuous case.
  - No duplicate or dropped writes.
  - `busy` stays 1 from `start` through DONE.
- **Extra `start`:** pulse `start` during LOAD_A and again during DONE → no restart; counters and sequence unaffected.
- **Reset mid-load:** assert `rst` low at B beat 20 → outputs 0 immediately. A new `start` then restarts at A r0 c0: first write `wr_en_A` = 0001, address 0.
- **N1 = 1, N2 = 8 config:**
  - A: `wr_en_A` is a single bit, always 1 on a write, with addr = r·8 + c.
  - B beat (r2, c7) → `wr_en_B` = 10000000, addr = 2.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix-multiply front end.
// Holds the loader FSM state type, a floor-1 clog2 width helper used by both
// the fill side and the read-side control, and default address widths.
package systolic_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StDone
  } load_state_e;

  // $clog2 that never returns 0, so a degenerate size still gets a 1-bit field.
  function automatic int unsigned clog2_f1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  localparam int unsigned DefM  = 8;
  localparam int unsigned DefN1 = 4;
  localparam int unsigned DefN2 = 4;

  localparam int unsigned AAddrW = clog2_f1(DefM * DefM / DefN1);
  localparam int unsigned BAddrW = clog2_f1(DefM * DefM / DefN2);

endpackage

// File: rtl/rc_counter.sv
// Row/column position counter for a row-major M x M stream.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : synchronous clear (wins over en_i)
//   en_i          : advance one element
//   row_o, col_o  : current position
//   last_o        : position is (M-1, M-1)
module rc_counter
  import systolic_pkg::*;
#(
  parameter int unsigned M = 8,
  parameter int unsigned W = clog2_f1(M)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] row_o,
  output logic [W-1:0] col_o,
  output logic         last_o
);

  logic [W-1:0] row_q, row_d;
  logic [W-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_q == W'(M - 1)) begin
        col_d = '0;
        row_d = (row_q == W'(M - 1)) ? '0 : row_q + W'(1);
      end else begin
        col_d = col_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == W'(M - 1)) && (col_q == W'(M - 1));

endmodule

// File: rtl/systolic_loader.sv
// Fill stage for the systolic multiplier: takes one valid/ready stream carrying
// matrix A then matrix B (each row-major, M x M) and scatters the elements into
// the banked A/B buffers in the layout the read-side address generator expects.
//   clk_i, rst_ni              : clock, async active-low reset
//   start_i                    : begin a load (only looked at while idle)
//   in_valid_i, in_data_i      : stream element
//   in_ready_o                 : element accepted this cycle when valid
//   wr_en_a_o/addr/data        : one-hot A bank write port (bank = row mod N1)
//   wr_en_b_o/addr/data        : one-hot B bank write port (bank = col mod N2)
//   busy_o                     : a load is in progress
//   load_done_o                : one-cycle pulse, both matrices resident
// All outputs are registered; a write appears the cycle after its beat.
module systolic_loader
  import systolic_pkg::*;
#(
  parameter int unsigned N1 = DefN1,
  parameter int unsigned N2 = DefN2,
  parameter int unsigned M  = DefM,
  parameter int unsigned DW = 8,
  localparam int unsigned AAW = clog2_f1(M * M / N1),
  localparam int unsigned BAW = clog2_f1(M * M / N2)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic           in_valid_i,
  input  logic [DW-1:0]  in_data_i,
  output logic           in_ready_o,
  output logic [N1-1:0]  wr_en_a_o,
  output logic [AAW-1:0] wr_addr_a_o,
  output logic [DW-1:0]  wr_data_a_o,
  output logic [N2-1:0]  wr_en_b_o,
  output logic [BAW-1:0] wr_addr_b_o,
  output logic [DW-1:0]  wr_data_b_o,
  output logic           busy_o,
  output logic           load_done_o
);

  localparam int unsigned RW    = clog2_f1(M);
  localparam int unsigned LogN1 = $clog2(N1);
  localparam int unsigned LogN2 = $clog2(N2);

  load_state_e state_q, state_d;

  logic [RW-1:0] row, col;
  logic          last;
  logic          accept;
  logic          cnt_clr;

  logic           in_ready_q, in_ready_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N1-1:0]  wr_en_a_q, wr_en_a_d;
  logic [AAW-1:0] wr_addr_a_q, wr_addr_a_d;
  logic [DW-1:0]  wr_data_a_q, wr_data_a_d;
  logic [N2-1:0]  wr_en_b_q, wr_en_b_d;
  logic [BAW-1:0] wr_addr_b_q, wr_addr_b_d;
  logic [DW-1:0]  wr_data_b_q, wr_data_b_d;

  assign accept = in_valid_i & in_ready_q;

  // Held at zero outside the load phases; the final beat of a phase also clears
  // so the next phase always starts at (0, 0).
  assign cnt_clr = (state_q == StIdle) || (state_q == StDone) || (accept && last);

  rc_counter #(
    .M(M),
    .W(RW)
  ) u_rc_counter (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (cnt_clr),
    .en_i  (accept),
    .row_o (row),
    .col_o (col),
    .last_o(last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StLoadA;
      StLoadA: if (accept && last) state_d = StLoadB;
      StLoadB: if (accept && last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_comb begin
    in_ready_d = (state_d == StLoadA) || (state_d == StLoadB);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
  end

  // A: bank = row mod N1, addr = {row / N1, col}.
  // B: bank = col mod N2, addr = {col / N2, row}.
  always_comb begin
    wr_en_a_d   = '0;
    wr_addr_a_d = wr_addr_a_q;
    wr_data_a_d = wr_data_a_q;
    wr_en_b_d   = '0;
    wr_addr_b_d = wr_addr_b_q;
    wr_data_b_d = wr_data_b_q;
    if (accept && (state_q == StLoadA)) begin
      wr_en_a_d   = N1'(1) << (row & RW'(N1 - 1));
      wr_addr_a_d = AAW'({row >> LogN1, col});
      wr_data_a_d = in_data_i;
    end
    if (accept && (state_q == StLoadB)) begin
      wr_en_b_d   = N2'(1) << (col & RW'(N2 - 1));
      wr_addr_b_d = BAW'({col >> LogN2, row});
      wr_data_b_d = in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_a_q   <= '0;
      wr_addr_a_q <= '0;
      wr_data_a_q <= '0;
      wr_en_b_q   <= '0;
      wr_addr_b_q <= '0;
      wr_data_b_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_en_a_q   <= wr_en_a_d;
      wr_addr_a_q <= wr_addr_a_d;
      wr_data_a_q <= wr_data_a_d;
      wr_en_b_q   <= wr_en_b_d;
      wr_addr_b_q <= wr_addr_b_d;
      wr_data_b_q <= wr_data_b_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign busy_o      = busy_q;
  assign load_done_o = done_q;
  assign wr_en_a_o   = wr_en_a_q;
  assign wr_addr_a_o = wr_addr_a_q;
  assign wr_data_a_o = wr_data_a_q;
  assign wr_en_b_o   = wr_en_b_q;
  assign wr_addr_b_o = wr_addr_b_q;
  assign wr_data_b_o = wr_data_b_q;

endmodule
